// File: rtl/lut_sweep_checker_if.sv
// Bundle between the LUT sweep checker and whatever drives/observes it.
// The checker takes the slave side; the controlling side (bench or bring-up logic) takes master.
interface lut_sweep_checker_if #(
    parameter int N_INPUTS  = 10,
    parameter int OUT_WIDTH = 11
);
    logic                 start;
    logic [N_INPUTS-1:0]  x_o;
    logic [OUT_WIDTH-1:0] f_i;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_INPUTS:0]    err_count;
    logic [N_INPUTS-1:0]  fail_idx;
    logic [OUT_WIDTH-1:0] fail_got;
    logic [OUT_WIDTH-1:0] fail_exp;

    modport master (
        output start, f_i,
        input  x_o, busy, done, pass, err_count, fail_idx, fail_got, fail_exp
    );

    modport slave (
        input  start, f_i,
        output x_o, busy, done, pass, err_count, fail_idx, fail_got, fail_exp
    );
endinterface

// File: rtl/lut_sweep_checker.sv
// Exhaustive on-chip sweep of a LUT netlist: drives every x, waits LAT cycles,
// compares f against the golden table and records the first mismatch plus a count.
module lut_sweep_checker #(
    parameter int N_INPUTS     = 10,
    parameter int OUT_WIDTH    = 11,
    parameter logic [(OUT_WIDTH<<N_INPUTS)-1:0] TT = '0,
    parameter int LAT          = 0,
    parameter int STOP_ON_FAIL = 1
) (
    input logic               clk,
    input logic               rst,
    lut_sweep_checker_if.slave bus
);
    localparam logic [3:0] LAT_W = 4'(LAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [N_INPUTS-1:0]  x_q, x_d;
    logic [3:0]           w_q, w_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [N_INPUTS:0]    err_q, err_d;
    logic [N_INPUTS-1:0]  fidx_q, fidx_d;
    logic [OUT_WIDTH-1:0] fgot_q, fgot_d;
    logic [OUT_WIDTH-1:0] fexp_q, fexp_d;

    logic [OUT_WIDTH-1:0] exp_entry;
    logic                 mismatch;
    logic                 finish;

    always_comb begin
        exp_entry = TT[int'(x_q) * OUT_WIDTH +: OUT_WIDTH];
        // Case inequality so an X/Z from the netlist is flagged in simulation.
        mismatch  = (bus.f_i !== exp_entry);
        finish    = (mismatch && (STOP_ON_FAIL != 0)) || (x_q == '1);

        state_d = state_q;
        x_d     = x_q;
        w_d     = w_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fgot_d  = fgot_q;
        fexp_d  = fexp_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    x_d     = '0;
                    w_d     = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    fidx_d  = '0;
                    fgot_d  = '0;
                    fexp_d  = '0;
                end
            end
            RUN: begin
                if (w_q != LAT_W) begin
                    w_d = w_q + 4'd1;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (err_q == '0) begin
                            fidx_d = x_q;
                            fgot_d = bus.f_i;
                            fexp_d = exp_entry;
                        end
                    end
                    if (finish) begin
                        // x_o stays on the last compared vector.
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        x_d = x_q + 1'b1;
                        w_d = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            fexp_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            fexp_q  <= fexp_d;
        end
    end

    assign bus.x_o       = x_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_idx  = fidx_q;
    assign bus.fail_got  = fgot_q;
    assign bus.fail_exp  = fexp_q;
endmodule

// File: tb/tb_lut_sweep_checker.sv
// Bench for lut_sweep_checker: small 2-input configs with behavioural LUT models
// (correct, faulty, two-stage registered) plus one full 10-input sweep.
module tb_lut_sweep_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic [11:0]    TT_S  = 12'hFAC;
    localparam logic [11263:0] TT_10 = {256{11'h7FF, 11'h2AA, 11'h155, 11'h000}};

    localparam int M_OK = 0, M_BAD2 = 1, M_BAD13 = 2, M_ALLBAD = 3, M_REG = 4;

    lut_sweep_checker_if #(.N_INPUTS(2),  .OUT_WIDTH(3))  b0 ();
    lut_sweep_checker_if #(.N_INPUTS(2),  .OUT_WIDTH(3))  b1 ();
    lut_sweep_checker_if #(.N_INPUTS(2),  .OUT_WIDTH(3))  b2 ();
    lut_sweep_checker_if #(.N_INPUTS(10), .OUT_WIDTH(11)) b3 ();

    lut_sweep_checker #(.N_INPUTS(2), .OUT_WIDTH(3), .TT(TT_S), .LAT(0), .STOP_ON_FAIL(1))
        dut0 (.clk(clk), .rst(rst), .bus(b0));
    lut_sweep_checker #(.N_INPUTS(2), .OUT_WIDTH(3), .TT(TT_S), .LAT(0), .STOP_ON_FAIL(0))
        dut1 (.clk(clk), .rst(rst), .bus(b1));
    lut_sweep_checker #(.N_INPUTS(2), .OUT_WIDTH(3), .TT(TT_S), .LAT(2), .STOP_ON_FAIL(1))
        dut2 (.clk(clk), .rst(rst), .bus(b2));
    lut_sweep_checker #(.N_INPUTS(10), .OUT_WIDTH(11), .TT(TT_10), .LAT(0), .STOP_ON_FAIL(1))
        dut3 (.clk(clk), .rst(rst), .bus(b3));

    // Golden small table: entry x is x+4.
    function automatic logic [2:0] ref_s(input logic [1:0] x);
        return 3'(x) + 3'd4;
    endfunction

    function automatic logic [2:0] model(input int md, input logic [1:0] x, input logic [2:0] reg_out);
        case (md)
            M_BAD2:   return (x == 2'd2) ? 3'd0 : ref_s(x);
            M_BAD13:  return (x == 2'd1 || x == 2'd3) ? 3'd0 : ref_s(x);
            M_ALLBAD: return 3'd0;
            M_REG:    return reg_out;
            default:  return ref_s(x);
        endcase
    endfunction

    int mode = M_OK;
    int sel  = 0;

    // Two-register-stage netlist model per small DUT.
    logic [1:0] s1_0, s1_1, s1_2;
    logic [2:0] s2_0, s2_1, s2_2;
    always_ff @(posedge clk) begin
        s1_0 <= b0.x_o; s2_0 <= ref_s(s1_0);
        s1_1 <= b1.x_o; s2_1 <= ref_s(s1_1);
        s1_2 <= b2.x_o; s2_2 <= ref_s(s1_2);
    end

    always_comb begin
        b0.f_i = model(mode, b0.x_o, s2_0);
        b1.f_i = model(mode, b1.x_o, s2_1);
        b2.f_i = model(mode, b2.x_o, s2_2);
        case (b3.x_o[1:0])
            2'd0:    b3.f_i = 11'h000;
            2'd1:    b3.f_i = 11'h155;
            2'd2:    b3.f_i = 11'h2AA;
            default: b3.f_i = 11'h7FF;
        endcase
    end

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       pass;
        logic [2:0] err;
        logic [1:0] idx;
        logic [2:0] got;
        logic [2:0] expv;
        logic [1:0] x;
    } obs_t;
    obs_t ob;

    always_comb begin
        ob = '0;
        case (sel)
            0: ob = {b0.done, b0.busy, b0.pass, b0.err_count, b0.fail_idx, b0.fail_got, b0.fail_exp, b0.x_o};
            1: ob = {b1.done, b1.busy, b1.pass, b1.err_count, b1.fail_idx, b1.fail_got, b1.fail_exp, b1.x_o};
            2: ob = {b2.done, b2.busy, b2.pass, b2.err_count, b2.fail_idx, b2.fail_got, b2.fail_exp, b2.x_o};
            default: ob = '0;
        endcase
    end

    typedef struct {
        int         dut;
        int         md;
        int         cyc;
        logic       pass;
        logic [2:0] err;
        logic [1:0] idx;
        logic [2:0] got;
        logic [2:0] expv;
    } vec_t;

    vec_t vt[7];
    vec_t exp_q[$];
    logic [1:0] xs[16];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0: b0.start = v;
            1: b1.start = v;
            2: b2.start = v;
            default: b3.start = v;
        endcase
    endtask

    task automatic run_sweep(input int d, input int md, input int pulse_at, output int cyc, output bit to);
        mode = md;
        sel  = d;
        to   = 1'b0;
        @(negedge clk);
        set_start(d, 1'b1);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            set_start(d, cyc == pulse_at);
            if (cyc < 16) xs[cyc] = ob.x;
            if (ob.done) break;
            if (cyc >= 2000) begin to = 1'b1; break; end
        end
    endtask

    task automatic score(input int cyc, input bit to, input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: scoreboard empty at done", tag);
            return;
        end
        e = exp_q.pop_front();
        if (to) begin
            n_chk++;
            $display("FAIL %s timeout: no done within 2000 cycles, expected cycle %0d", tag, e.cyc);
            return;
        end
        chk({tag, ".done_cycle"}, 32'(cyc), 32'(e.cyc));
        chk({tag, ".pass"},       32'(ob.pass), 32'(e.pass));
        chk({tag, ".err_count"},  32'(ob.err),  32'(e.err));
        chk({tag, ".fail_idx"},   32'(ob.idx),  32'(e.idx));
        chk({tag, ".fail_got"},   32'(ob.got),  32'(e.got));
        chk({tag, ".fail_exp"},   32'(ob.expv), 32'(e.expv));
        chk({tag, ".busy_at_done"}, 32'(ob.busy), 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  to;
        logic [9:0] x3_last;

        //           dut md        cyc pass err  idx  got  exp
        vt[0] = '{0, M_OK,     5,  1'b1, 3'd0, 2'd0, 3'd0, 3'd0};
        vt[1] = '{0, M_BAD2,   4,  1'b0, 3'd1, 2'd2, 3'd0, 3'd6};
        vt[2] = '{0, M_REG,    2,  1'b0, 3'd1, 2'd0, 3'd6, 3'd4};
        vt[3] = '{1, M_BAD13,  5,  1'b0, 3'd2, 2'd1, 3'd0, 3'd5};
        vt[4] = '{2, M_REG,    13, 1'b1, 3'd0, 2'd0, 3'd0, 3'd0};
        vt[5] = '{1, M_OK,     5,  1'b1, 3'd0, 2'd0, 3'd0, 3'd0};
        vt[6] = '{1, M_ALLBAD, 5,  1'b0, 3'd4, 2'd0, 3'd0, 3'd4};

        rst = 1'b1;
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0; b3.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.x_o",       32'(b0.x_o), 32'd0);
        chk("rst.busy",      32'(b0.busy), 32'd0);
        chk("rst.done",      32'(b0.done), 32'd0);
        chk("rst.pass",      32'(b0.pass), 32'd0);
        chk("rst.err_count", 32'(b0.err_count), 32'd0);
        chk("rst.fail_idx",  32'(b0.fail_idx), 32'd0);
        chk("rst.fail_got",  32'(b0.fail_got), 32'd0);
        chk("rst.fail_exp",  32'(b0.fail_exp), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vt[i]);
            run_sweep(vt[i].dut, vt[i].md, -1, cyc, to);
            score(cyc, to, $sformatf("vec%0d", i));
            if (i == 0)
                for (int c = 1; c <= 4; c++) chk($sformatf("vec0.x_o_c%0d", c), 32'(xs[c]), 32'(c - 1));
            repeat (3) @(negedge clk);
        end

        // start pulsed mid-sweep must not disturb timing
        exp_q.push_back('{2, M_REG, 13, 1'b1, 3'd0, 2'd0, 3'd0, 3'd0});
        run_sweep(2, M_REG, 2, cyc, to);
        score(cyc, to, "start_ignored");
        chk("start_ignored.x_o_c4", 32'(xs[4]), 32'd1);
        chk("start_ignored.x_o_c7", 32'(xs[7]), 32'd2);
        repeat (3) @(negedge clk);

        // reset mid-sweep
        mode = M_ALLBAD; sel = 1;
        @(negedge clk); b1.start = 1'b1;
        @(negedge clk); b1.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.err_before", 32'(b1.err_count), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.x_o",       32'(b1.x_o), 32'd0);
        chk("midrst.busy",      32'(b1.busy), 32'd0);
        chk("midrst.done",      32'(b1.done), 32'd0);
        chk("midrst.pass",      32'(b1.pass), 32'd0);
        chk("midrst.err_count", 32'(b1.err_count), 32'd0);
        chk("midrst.fail_idx",  32'(b1.fail_idx), 32'd0);
        chk("midrst.fail_exp",  32'(b1.fail_exp), 32'd0);
        @(negedge clk);
        chk("midrst.idle_busy", 32'(b1.busy), 32'd0);

        // restart after reset begins again from x_o=0
        exp_q.push_back('{1, M_OK, 5, 1'b1, 3'd0, 2'd0, 3'd0, 3'd0});
        run_sweep(1, M_OK, -1, cyc, to);
        score(cyc, to, "restart");
        chk("restart.x_o_c1", 32'(xs[1]), 32'd0);
        chk("restart.x_o_c2", 32'(xs[2]), 32'd1);
        repeat (3) @(negedge clk);

        // full-size sweep
        @(negedge clk); b3.start = 1'b1;
        cyc = 0; to = 1'b0; x3_last = '0;
        forever begin
            @(negedge clk);
            cyc++;
            b3.start = 1'b0;
            if (cyc == 1024) x3_last = b3.x_o;
            if (b3.done) break;
            if (cyc >= 2000) begin to = 1'b1; break; end
        end
        if (to) begin
            n_chk++;
            $display("FAIL full.timeout: no done within 2000 cycles, expected cycle 1025");
        end else begin
            chk("full.done_cycle", 32'(cyc), 32'd1025);
            chk("full.pass",       32'(b3.pass), 32'd1);
            chk("full.err_count",  32'(b3.err_count), 32'd0);
            chk("full.x_o_c1024",  32'(x3_last), 32'd1023);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lut_sweep_checker.md
# lut_sweep_checker

Synchronous on-chip exhaustive checker that sits directly upstream of a synthesized LUT netlist (`top`: input `x`, output `f`). It drives every input pattern `0 … 2^N_INPUTS-1` onto `x`, samples `f` after a configurable settle latency, and compares the sample against the golden truth table `TT`. It reports pass/fail, the first mismatch and a mismatch count. This is the hardware counterpart of the simulation sweep bench, for use on FPGA bring-up and in pipelined-mapping experiments.

## Interface
- `N_INPUTS`, default 10: L-LUT input width.
- `OUT_WIDTH`, default 11: L-LUT output width.
- `TT`, default all-zero, width `OUT_WIDTH<<N_INPUTS`: golden table. Entry `i` is `TT[i*OUT_WIDTH +: OUT_WIDTH]`.
- `LAT`, default 0, range 0..15: cycles between driving `x_o` and sampling `f_i`.
- `STOP_ON_FAIL`, default 1: 1 ends the sweep at the first mismatch; 0 completes the full sweep.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `x_o`  out  `N_INPUTS`  registered stimulus, connected to DUT `x`.
- `f_i`  in  `OUT_WIDTH`  DUT output `f`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  1 when the last sweep had zero mismatches; held until the next start.
- `err_count`  out  `N_INPUTS+1`  number of mismatching vectors; cannot overflow.
- `fail_idx`  out  `N_INPUTS`  index of the first mismatch.
- `fail_got`  out  `OUT_WIDTH`  `f_i` value at the first mismatch.
- `fail_exp`  out  `OUT_WIDTH`  `TT` entry at the first mismatch.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: drive vector `x_o`; a wait counter `w` counts 0..LAT.
  - DONE: one cycle; pulse `done`, return to IDLE.
- IDLE with `start=1`:
  - next state RUN, `x_o=0`, `w=0`, `busy=1`.
  - clear `err_count`, `fail_*` and `pass`.
- RUN with `w<LAT`: increment `w`; `x_o` held.
- RUN with `w==LAT` (compare cycle):
  - compare `f_i` against `TT[x_o*OUT_WIDTH +: OUT_WIDTH]` using 4-state inequality; X/Z on `f_i` counts as a mismatch in simulation.
  - On mismatch: increment `err_count`. If it was 0, capture `fail_idx=x_o`, `fail_got=f_i`, `fail_exp` = the table entry.
  - Mismatch and `STOP_ON_FAIL=1`: go to DONE.
  - Else if `x_o` is the all-ones value: go to DONE. `x_o` does not wrap; it holds its last value.
  - Else: `x_o<=x_o+1`, `w<=0`.
- DONE: `done=1`, `busy=0`, `pass=(err_count==0)`. `x_o` holds. Next state IDLE.
- `start` in RUN or DONE is ignored; there is no queuing.
- `rst` has priority over everything, including a mid-sweep state. On reset:
  - state IDLE.
  - `x_o`, `busy`, `done`, `pass`, `err_count`, `fail_idx`, `fail_got`, `fail_exp` all 0.

## Timing
- Start accepted at edge E0. Vector `i` is on `x_o` during cycles `1+i*(LAT+1)` through `(i+1)*(LAT+1)`.
- The compare uses `f_i` in the last of those cycles.
- With no early stop, `done` is high in cycle `2^N_INPUTS*(LAT+1)+1`. `busy` is high in cycles 1 through `2^N_INPUTS*(LAT+1)`.
- With an early stop at index `k`, `done` is high in cycle `(k+1)*(LAT+1)+1`.
- A DUT with `p` register stages requires `LAT>=p`. A purely combinational DUT uses `LAT=0`.
- `pass`, `err_count` and `fail_*` are stable from the `done` cycle until the next accepted start or `rst`.
- The earliest new start is the cycle after `done`, with IDLE reached again.

## Test plan
Small-configuration tests use `N_INPUTS=2`, `OUT_WIDTH=3`, `TT=12'hFAC` (entries 4, 5, 6, 7).
- Correct combinational model, `LAT=0`, start at cycle 0 -> `x_o` = 0, 1, 2, 3 in cycles 1–4; `done` in cycle 5; `pass=1`; `err_count=0`.
- Model returns 0 for x=2, `STOP_ON_FAIL=1` -> `done` in cycle 4; `pass=0`; `fail_idx=2`; `fail_got=0`; `fail_exp=6`; `err_count=1`.
- `STOP_ON_FAIL=0`, model wrong on x=1 (returns 0) and on x=3 -> full sweep, `done` in cycle 5, `err_count=2`, `fail_idx=1`, `fail_got=0`, `fail_exp=5`.
- Two-stage registered model:
  - `LAT=2` -> `pass=1`, `done` in cycle 13.
  - `LAT=0` -> `pass=0`.
- Control checks:
  - `start` pulsed in cycle 2 of a sweep -> ignored; sweep timing unchanged.
  - `rst` in cycle 3 -> all outputs 0 next cycle.
  - Then `start` -> sweep restarts from `x_o=0`.
- Full configuration `N_INPUTS=10`, `OUT_WIDTH=11`, project `TT`, synthesized `top` as DUT, `LAT=0` -> `done` in cycle 1025 and `pass=1`.
